// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// presents it to decode with a valid/ready handshake, and redirects on branches.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [6:0]  opcode,
   output logic [31:0] pc_out,
   input  logic        branch_taken,
   input  logic [31:0] imm_ext,
   output logic        fetch_err,
   output logic [31:0] fetch_count
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, OUT, HALT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] next_pc;

   function automatic logic [31:0] redirect(input logic [31:0] base,
                                            input logic        taken,
                                            input logic [31:0] offset);
      return taken ? base + offset : base + 32'd4;
   endfunction

   assign next_pc   = redirect(pc_out, branch_taken, imm_ext);
   assign imem_addr = pc;
   assign opcode    = instr_out[6:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr_out   <= '0;
         pc_out      <= '0;
         fetch_err   <= 1'b0;
         fetch_count <= '0;
      end else begin
         case (state)
            BOOT: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               // Address stays on the bus until memory grants it.
               if (imem_gnt) begin
                  imem_req <= 1'b0;
                  if (imem_rvalid) begin
                     instr_out   <= imem_rdata;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                     state       <= OUT;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  instr_out   <= imem_rdata;
                  pc_out      <= pc;
                  instr_valid <= 1'b1;
                  state       <= OUT;
               end
            end
            OUT: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  fetch_count <= fetch_count + 32'd1;
                  pc          <= next_pc;
                  // A misaligned target is fatal: keep it visible in pc and stop fetching.
                  if (next_pc[1:0] == 2'b00) begin
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end else begin
                     state     <= HALT;
                     fetch_err <= 1'b1;
                  end
               end
            end
            HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level fetch model plus directed scenarios
// with hand-computed expectations.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [6:0]  opcode;
   logic [31:0] pc_out;
   logic        branch_taken = 1'b0;
   logic [31:0] imm_ext = '0;
   logic        fetch_err;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .opcode(opcode), .pc_out(pc_out),
      .branch_taken(branch_taken), .imm_ext(imm_ext),
      .fetch_err(fetch_err), .fetch_count(fetch_count)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder state
   bit          mem_en = 1'b0;
   bit          same_cycle = 1'b0;
   bit          fixed_mode = 1'b1;
   bit          pend = 1'b0;
   bit          resp_seen = 1'b0;
   logic [31:0] fixed_word = 32'h0000_0013;
   logic [31:0] pend_addr = '0;
   int          gnt_delay = 0;
   int          hold_cnt = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return fixed_mode ? fixed_word : {a[24:0], 7'b0010011};
   endfunction

   initial forever begin
      @(posedge clk); #1;
      if (mem_en) begin
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         if (pend) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(pend_addr);
            pend        = 1'b0;
            resp_seen   = 1'b1;
         end else if (imem_req) begin
            if (hold_cnt < gnt_delay) hold_cnt++;
            else begin
               hold_cnt = 0;
               imem_gnt = 1'b1;
               if (same_cycle) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = word_at(imem_addr);
                  resp_seen   = 1'b1;
               end else begin
                  pend      = 1'b1;
                  pend_addr = imem_addr;
               end
            end
         end
      end
   end

   // Fetch model: next fetch address, accept count, sticky error, halted flag.
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_count = '0;
   bit          m_err = 1'b0;
   bit          m_halt = 1'b0;
   logic [31:0] m_next;

   initial forever begin
      @(negedge clk);
      check("opcode_field", {25'd0, opcode}, {25'd0, instr_out[6:0]});
      if (!rst_n) begin
         check("rst_imem_req", {31'd0, imem_req}, 32'd0);
         check("rst_imem_addr", imem_addr, RESET_PC);
         check("rst_valid", {31'd0, instr_valid}, 32'd0);
         check("rst_instr_out", instr_out, 32'd0);
         check("rst_pc_out", pc_out, 32'd0);
         check("rst_count", fetch_count, 32'd0);
         check("rst_err", {31'd0, fetch_err}, 32'd0);
         m_pc = RESET_PC; m_count = '0; m_err = 1'b0; m_halt = 1'b0; resp_seen = 1'b0;
      end else begin
         check("fetch_count", fetch_count, m_count);
         check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
         if (m_halt) begin
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
         end
         if (imem_req) check("imem_addr", imem_addr, m_pc);
         if (instr_valid) begin
            check("pc_out", pc_out, m_pc);
            check("instr_out", instr_out, word_at(m_pc));
            check("valid_without_resp", {31'd0, resp_seen}, 32'd1);
            if (instr_ready) begin
               m_next    = branch_taken ? m_pc + imm_ext : m_pc + 32'd4;
               m_count   = m_count + 32'd1;
               m_pc      = m_next;
               resp_seen = 1'b0;
               if (m_next[1:0] != 2'b00) begin
                  m_err  = 1'b1;
                  m_halt = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mem_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      pend = 1'b0; hold_cnt = 0; resp_seen = 1'b0;
      instr_ready = 1'b0; branch_taken = 1'b0; imm_ext = '0;
      #1;
      check("async_rst_req", {31'd0, imem_req}, 32'd0);
      check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("async_rst_count", fetch_count, 32'd0);
      check("async_rst_err", {31'd0, fetch_err}, 32'd0);
      check("async_rst_addr", imem_addr, RESET_PC);
      tick(); tick();
   endtask

   task automatic wait_valid(input string name, output int n);
      n = 0;
      while (!instr_valid && n < 50) begin tick(); n++; end
      check(name, {31'd0, instr_valid}, 32'd1);
   endtask

   initial begin
      int n;
      logic [31:0] cnt_before;
      #1;
      // Same-cycle grant+data, then a long stall in OUT with stray memory pulses
      do_reset();
      fixed_mode = 1'b1; fixed_word = 32'h0062_8063; same_cycle = 1'b1; gnt_delay = 0;
      mem_en = 1'b1; rst_n = 1'b1;
      wait_valid("valid_same_cycle", n);
      check("latency_same_cycle", 32'(n), 32'd2);
      check("opcode_branch", {25'd0, opcode}, {25'd0, 7'b1100011});
      check("pc_first", pc_out, 32'd0);
      mem_en = 1'b0; branch_taken = 1'b1; imm_ext = 32'h0000_0100;
      for (int i = 0; i < 5; i++) begin
         imem_gnt = ~i[0]; imem_rvalid = ~i[0]; imem_rdata = 32'hBAD0_0BAD;
         tick();
         check("stall_instr", instr_out, 32'h0062_8063);
         check("stall_pc", pc_out, 32'd0);
         check("stall_req", {31'd0, imem_req}, 32'd0);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; branch_taken = 1'b0; imm_ext = '0;
      mem_en = 1'b1; instr_ready = 1'b1;
      tick();
      check("count_after_stall", fetch_count, 32'd1);
      check("req_after_accept", {31'd0, imem_req}, 32'd1);
      check("addr_after_accept", imem_addr, 32'd4);

      // Sequential fetch with data one cycle after grant
      do_reset();
      fixed_mode = 1'b1; fixed_word = 32'h0000_0013; same_cycle = 1'b0; gnt_delay = 0;
      mem_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_valid("valid_seq", n);
         check("pc_seq", pc_out, 32'(i * 4));
         tick();
         check("count_seq", fetch_count, 32'(i + 1));
         check("addr_seq", imem_addr, 32'((i + 1) * 4));
      end

      // Slow grant; branch asserted outside accepts must not redirect; backward branch at 0x10
      gnt_delay = 2;
      n = 0;
      while (!(instr_valid && pc_out == 32'h10) && n < 100) begin
         if (instr_valid) begin branch_taken = 1'b0; imm_ext = '0; instr_ready = 1'b1; end
         else begin branch_taken = 1'b1; imm_ext = 32'h100; instr_ready = 1'b0; end
         tick(); n++;
      end
      check("reach_pc_10", {31'd0, instr_valid && pc_out == 32'h10}, 32'd1);
      instr_ready = 1'b1; branch_taken = 1'b1; imm_ext = 32'hFFFF_FFF8;
      tick();
      branch_taken = 1'b0; imm_ext = '0;
      check("branch_addr", imem_addr, 32'h8);
      check("branch_req", {31'd0, imem_req}, 32'd1);
      check("branch_count", fetch_count, 32'd5);
      wait_valid("valid_after_branch", n);
      check("pc_after_branch", pc_out, 32'h8);
      tick();

      // Mixed ready/branch traffic, then reset while waiting for data
      do_reset();
      fixed_mode = 1'b0; same_cycle = 1'b0; gnt_delay = 1; mem_en = 1'b1; rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
         instr_ready  = (k % 3) != 0;
         branch_taken = k[0];
         imm_ext      = (k % 4 == 0) ? 32'h20 : 32'hFFFF_FFF0;
         tick();
      end
      instr_ready = 1'b1; branch_taken = 1'b0; imm_ext = '0;
      n = 0;
      while (!pend && n < 50) begin tick(); n++; end
      check("found_grant", {31'd0, pend}, 32'd1);
      mem_en = 1'b0;
      tick();
      check("wait_req", {31'd0, imem_req}, 32'd0);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      cnt_before = fetch_count;
      check("traffic_accepted", {31'd0, cnt_before > 32'd5}, 32'd1);
      do_reset();
      rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick(); tick();
      check("stale_valid", {31'd0, instr_valid}, 32'd0);
      check("stale_instr", instr_out, 32'd0);
      check("stale_req", {31'd0, imem_req}, 32'd1);
      check("stale_addr", imem_addr, RESET_PC);
      imem_rvalid = 1'b0; mem_en = 1'b1;
      wait_valid("valid_after_stale", n);
      check("pc_after_stale", pc_out, RESET_PC);
      check("instr_after_stale", instr_out, 32'h0000_0013);

      // Misaligned branch target halts fetching
      do_reset();
      fixed_mode = 1'b1; fixed_word = 32'h0000_0013; same_cycle = 1'b1; gnt_delay = 0;
      mem_en = 1'b1; rst_n = 1'b1;
      wait_valid("valid_halt", n);
      check("pc_halt", pc_out, 32'd0);
      instr_ready = 1'b1; branch_taken = 1'b1; imm_ext = 32'h2;
      tick();
      branch_taken = 1'b0; imm_ext = '0;
      check("halt_err", {31'd0, fetch_err}, 32'd1);
      check("halt_count", fetch_count, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("halt_req_hold", {31'd0, imem_req}, 32'd0);
         check("halt_valid_hold", {31'd0, instr_valid}, 32'd0);
      end
      do_reset();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address (word-aligned).
REQ-006 imem_gnt  input  1  memory accepted the request this cycle.
REQ-007 imem_rvalid  input  1  imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instr_out, pc_out and opcode are valid.
REQ-010 instr_ready  input  1  decode/ImmGen stage consumes the instruction this cycle.
REQ-011 instr_out  output  32  registered instruction word.
REQ-012 opcode  output  7  instr_out[6:0], fed to the immediate generator.
REQ-013 pc_out  output  32  address of instr_out.
REQ-014 branch_taken  input  1  redirect request, sampled only on accept.
REQ-015 imm_ext  input  32  sign-extended branch offset from the immediate generator.
REQ-016 fetch_err  output  1  sticky misaligned-target error.
REQ-017 fetch_count  output  32  number of accepted instructions.

Function
REQ-018 FSM states SHALL be BOOT, REQ, WAIT, OUT, HALT, with BOOT entered on reset.
REQ-019 BOOT SHALL last exactly one cycle after rst_n deasserts, then go to REQ.
REQ-020 In REQ, imem_req=1 and imem_addr=pc SHALL be held stable until imem_gnt=1.
REQ-021 On REQ with imem_gnt=1 and imem_rvalid=0, the FSM SHALL go to WAIT.
REQ-022 On REQ with imem_gnt=1 and imem_rvalid=1 in the same cycle, imem_rdata SHALL be captured and the FSM SHALL go directly to OUT.
REQ-023 In WAIT, imem_req=0; on imem_rvalid=1, imem_rdata SHALL be captured into instr_out and the FSM SHALL go to OUT.
REQ-024 imem_rvalid in BOOT, REQ without imem_gnt, OUT or HALT SHALL be ignored.
REQ-025 In OUT, instr_valid=1 and instr_out/pc_out SHALL remain stable until instr_ready=1.
REQ-026 On accept (OUT and instr_ready=1), next pc SHALL be pc_out+imm_ext (mod 2^32) if branch_taken=1, else pc_out+4 (mod 2^32).
REQ-027 On accept, fetch_count SHALL increment by 1, wrapping 32'hFFFF_FFFF to 0.
REQ-028 On accept with aligned next pc (bits[1:0]=2'b00), the FSM SHALL go to REQ the following cycle (minimum 2 cycles accept-to-next-valid with same-cycle response).
REQ-029 On accept with misaligned next pc, fetch_err SHALL set, pc SHALL hold the misaligned value, and the FSM SHALL go to HALT.
REQ-030 HALT SHALL keep imem_req=0 and instr_valid=0 until reset; fetch_err remains 1.
REQ-031 branch_taken and imm_ext SHALL be ignored in every cycle other than an accept.
REQ-032 opcode SHALL equal instr_out[6:0] at all times.

Reset
REQ-033 rst_n=0 SHALL immediately force: state BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=0, fetch_err=0, fetch_count=0.
REQ-034 Reset during WAIT SHALL abandon the outstanding request; a late imem_rvalid after reset SHALL be ignored per REQ-024.

Verification
REQ-035 Reset release, memory grants immediately with rvalid next cycle, rdata=32'h0000_0013, instr_ready=1 -> imem_addr sequence 0,4,8; pc_out 0,4,8; fetch_count 1,2,3.
REQ-036 Same-cycle gnt+rvalid, rdata=32'h0062_8063 -> instr_valid rises next cycle, opcode=7'b1100011, pc_out=0.
REQ-037 Accept at pc_out=32'h10 with branch_taken=1, imm_ext=32'hFFFF_FFF8 -> next imem_addr=32'h08; branch_taken=1 while not accepting -> no effect.
REQ-038 instr_ready=0 for 5 cycles in OUT, gnt/rvalid pulsed meanwhile -> instr_out, pc_out stable, imem_req=0, no capture.
REQ-039 Accept with branch_taken=1, imm_ext=32'h2 at pc_out=0 -> fetch_err=1, HALT, imem_req=0 until rst_n=0.
REQ-040 rst_n=0 asserted in WAIT, rvalid arrives 1 cycle after release -> outputs at reset values, first request to RESET_PC, stale data not captured.
